// File: rtl/vga_if.sv
// vga_if: one VGA pixel stream (counters, sync, blanking, 4:4:4 colour).
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/screen_mux.sv
// screen_mux: selects one of N_SCREENS VGA streams, switching only on frame
// edges, with an optional multi-frame fade to black and back on each change.
module screen_mux #(
   parameter int N_SCREENS   = 4,
   parameter int SEL_W       = $clog2(N_SCREENS),
   parameter int DEFAULT_SEL = 0,
   parameter int FADE_EN     = 1,
   parameter int LEVEL_W     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SEL_W-1:0]        sel,
   input  logic [N_SCREENS*11-1:0] src_hcount,
   input  logic [N_SCREENS*11-1:0] src_vcount,
   input  logic [N_SCREENS-1:0]    src_hsync,
   input  logic [N_SCREENS-1:0]    src_vsync,
   input  logic [N_SCREENS-1:0]    src_hblnk,
   input  logic [N_SCREENS-1:0]    src_vblnk,
   input  logic [N_SCREENS*12-1:0] src_rgb,
   vga_if.out                      mux_out,
   output logic [SEL_W-1:0]        active_sel,
   output logic                    busy,
   output logic                    sel_err
);
   // Select space is padded to a power of two so any index value is in range.
   localparam int               N_SLOTS = 2**SEL_W;
   localparam logic [SEL_W-1:0] DEF_SEL = DEFAULT_SEL[SEL_W-1:0];
   localparam logic [SEL_W:0]   N_VAL   = N_SCREENS[SEL_W:0];
   localparam logic [LEVEL_W:0] FULL    = {1'b1, {LEVEL_W{1'b0}}};
   localparam logic [LEVEL_W:0] ONE     = {{LEVEL_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {SHOW, FADE_OUT, FADE_IN} state_t;

   state_t            r_state, w_state_next;
   logic [LEVEL_W:0]  r_level, w_level_next;
   logic [SEL_W-1:0]  r_active, w_active_next;
   logic [SEL_W-1:0]  r_pending;
   logic              r_sel_err;

   logic [10:0] r_hc, r_vc;
   logic        r_hs, r_vs, r_hb, r_vb;
   logic [11:0] r_rgb;

   logic [10:0] w_hc [N_SLOTS];
   logic [10:0] w_vc [N_SLOTS];
   logic        w_hs [N_SLOTS];
   logic        w_vs [N_SLOTS];
   logic        w_hb [N_SLOTS];
   logic        w_vb [N_SLOTS];
   logic [11:0] w_rgb [N_SLOTS];

   logic [10:0] w_m_hc, w_m_vc;
   logic        w_m_hs, w_m_vs, w_m_hb, w_m_vb;
   logic [11:0] w_m_rgb, w_scaled, w_rgb_out;
   logic [4+LEVEL_W:0] w_prod [3];
   logic        w_edge, w_sel_ok;
   logic [LEVEL_W:0] w_lvl_dn, w_lvl_up;

   // Unpack the flat source buses; unused slots read as an idle black stream.
   generate
      for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_src
         if (gi < N_SCREENS) begin : g_real
            assign w_hc[gi]  = src_hcount[gi*11 +: 11];
            assign w_vc[gi]  = src_vcount[gi*11 +: 11];
            assign w_hs[gi]  = src_hsync[gi];
            assign w_vs[gi]  = src_vsync[gi];
            assign w_hb[gi]  = src_hblnk[gi];
            assign w_vb[gi]  = src_vblnk[gi];
            assign w_rgb[gi] = src_rgb[gi*12 +: 12];
         end else begin : g_pad
            assign w_hc[gi]  = '0;
            assign w_vc[gi]  = '0;
            assign w_hs[gi]  = 1'b0;
            assign w_vs[gi]  = 1'b0;
            assign w_hb[gi]  = 1'b0;
            assign w_vb[gi]  = 1'b0;
            assign w_rgb[gi] = '0;
         end
      end
   endgenerate

   assign w_m_hc  = w_hc[r_active];
   assign w_m_vc  = w_vc[r_active];
   assign w_m_hs  = w_hs[r_active];
   assign w_m_vs  = w_vs[r_active];
   assign w_m_hb  = w_hb[r_active];
   assign w_m_vb  = w_vb[r_active];
   assign w_m_rgb = w_rgb[r_active];

   // Brightness scaling per channel; full level reproduces the input exactly.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_scale
         assign w_prod[gi] = {{(LEVEL_W+1){1'b0}}, w_m_rgb[gi*4 +: 4]} * {4'b0000, r_level};
         assign w_scaled[gi*4 +: 4] = 4'(w_prod[gi] >> LEVEL_W);
      end
   endgenerate

   assign w_rgb_out = (w_m_hb | w_m_vb) ? 12'h000 : w_scaled;

   // Frame edge is judged against the registered output so that a misaligned
   // incoming source cannot produce a spurious edge on the switch cycle.
   assign w_edge   = w_m_vb & ~r_vb;
   assign w_sel_ok = ({1'b0, sel} < N_VAL);
   assign w_lvl_dn = (r_level == '0) ? '0 : r_level - ONE;
   assign w_lvl_up = (r_level == FULL) ? FULL : r_level + ONE;

   // Next-state logic: level and source only move on frame edges.
   always_comb begin
      w_state_next  = r_state;
      w_level_next  = r_level;
      w_active_next = r_active;
      if (w_edge) begin
         if (FADE_EN == 0) begin
            if (r_pending != r_active)
               w_active_next = r_pending;
         end else if (r_pending != r_active) begin
            // Darken one step; the source swaps on the edge that reaches black.
            w_level_next = w_lvl_dn;
            if (w_lvl_dn == '0) begin
               w_active_next = r_pending;
               w_state_next  = FADE_IN;
            end else begin
               w_state_next  = FADE_OUT;
            end
         end else if (r_state != SHOW) begin
            // Request settled (or reversed): brighten back toward full.
            w_level_next = w_lvl_up;
            w_state_next = (w_lvl_up == FULL) ? SHOW : FADE_IN;
         end
      end
   end

   // Control registers: state, level, selection and the invalid-select flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= SHOW;
         r_level   <= FULL;
         r_active  <= DEF_SEL;
         r_pending <= DEF_SEL;
         r_sel_err <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_level   <= w_level_next;
         r_active  <= w_active_next;
         r_sel_err <= ~w_sel_ok;
         if (w_sel_ok)
            r_pending <= sel;
      end
   end

   // Output stage: all stream fields registered together for 1-cycle latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hc  <= '0;
         r_vc  <= '0;
         r_hs  <= 1'b0;
         r_vs  <= 1'b0;
         r_hb  <= 1'b0;
         r_vb  <= 1'b0;
         r_rgb <= '0;
      end else begin
         r_hc  <= w_m_hc;
         r_vc  <= w_m_vc;
         r_hs  <= w_m_hs;
         r_vs  <= w_m_vs;
         r_hb  <= w_m_hb;
         r_vb  <= w_m_vb;
         r_rgb <= w_rgb_out;
      end
   end

   assign mux_out.hcount = r_hc;
   assign mux_out.vcount = r_vc;
   assign mux_out.hsync  = r_hs;
   assign mux_out.vsync  = r_vs;
   assign mux_out.hblnk  = r_hb;
   assign mux_out.vblnk  = r_vb;
   assign mux_out.rgb    = r_rgb;

   assign active_sel = r_active;
   assign busy       = (r_state != SHOW) || (r_pending != r_active);
   assign sel_err    = r_sel_err;
endmodule

// File: tb/tb_screen_mux.sv
// tb_screen_mux: two screen_mux instances (fade and hard cut) share one set of
// synthetic sources; a frame-level reference model predicts every output cycle.
module tb_screen_mux;
   localparam int N  = 4;
   localparam int SW = 3;
   localparam int HT = 16;
   localparam int VT = 8;

   typedef struct packed {
      logic [10:0] hc;
      logic [10:0] vc;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
      logic [2:0]  act;
      logic        busy;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic [SW-1:0] sel = '0;
   logic [N*11-1:0] src_hcount = '0;
   logic [N*11-1:0] src_vcount = '0;
   logic [N-1:0]    src_hsync = '0;
   logic [N-1:0]    src_vsync = '0;
   logic [N-1:0]    src_hblnk = '0;
   logic [N-1:0]    src_vblnk = '0;
   logic [N*12-1:0] src_rgb = '0;

   vga_if out_fade ();
   vga_if out_cut ();
   logic [SW-1:0] act_fade, act_cut;
   logic          busy_fade, busy_cut, err_fade, err_cut;

   screen_mux #(.N_SCREENS(N), .SEL_W(SW), .DEFAULT_SEL(0), .FADE_EN(1), .LEVEL_W(2)) u_fade (
      .clk(clk), .rst(rst), .sel(sel),
      .src_hcount(src_hcount), .src_vcount(src_vcount),
      .src_hsync(src_hsync), .src_vsync(src_vsync),
      .src_hblnk(src_hblnk), .src_vblnk(src_vblnk), .src_rgb(src_rgb),
      .mux_out(out_fade), .active_sel(act_fade), .busy(busy_fade), .sel_err(err_fade)
   );

   screen_mux #(.N_SCREENS(N), .SEL_W(SW), .DEFAULT_SEL(0), .FADE_EN(0), .LEVEL_W(2)) u_cut (
      .clk(clk), .rst(rst), .sel(sel),
      .src_hcount(src_hcount), .src_vcount(src_vcount),
      .src_hsync(src_hsync), .src_vsync(src_vsync),
      .src_hblnk(src_hblnk), .src_vblnk(src_vblnk), .src_rgb(src_rgb),
      .mux_out(out_cut), .active_sel(act_cut), .busy(busy_cut), .sel_err(err_cut)
   );

   exp_t q_fade[$];
   exp_t q_cut[$];
   int   m_act[2], m_pend[2], m_lvl[2];
   bit   m_vb[2];
   int   checks = 0;
   int   errors = 0;
   int   h = 0, v = 0, rgb_mode = 0, txn = 0;

   // Reference: shown screen, requested screen and brightness 0..4 per stream.
   // A frame starts when the shown stream's vblnk rises relative to the last
   // emitted pixel; on that boundary brightness steps toward black while a
   // different screen is wanted (swapping at black), otherwise back to full.
   task automatic model_step(input int k, input bit fe, input bit r, input int s, output exp_t e);
      int a;
      logic [11:0] c;
      logic [11:0] o;
      e = '0;
      if (r) begin
         m_act[k] = 0; m_pend[k] = 0; m_lvl[k] = 4; m_vb[k] = 1'b0;
         return;
      end
      a      = m_act[k];
      e.hc   = src_hcount[a*11 +: 11];
      e.vc   = src_vcount[a*11 +: 11];
      e.hs   = src_hsync[a];
      e.vs   = src_vsync[a];
      e.hb   = src_hblnk[a];
      e.vb   = src_vblnk[a];
      c      = src_rgb[a*12 +: 12];
      for (int ch = 0; ch < 3; ch++)
         o[ch*4 +: 4] = 4'((int'(c[ch*4 +: 4]) * m_lvl[k]) / 4);
      e.rgb = (e.hb || e.vb) ? 12'h000 : o;
      if (e.vb && !m_vb[k]) begin
         if (!fe) begin
            m_act[k] = m_pend[k];
         end else if (m_pend[k] != m_act[k]) begin
            m_lvl[k] = (m_lvl[k] > 0) ? m_lvl[k] - 1 : 0;
            if (m_lvl[k] == 0) m_act[k] = m_pend[k];
         end else if (m_lvl[k] < 4) begin
            m_lvl[k] = m_lvl[k] + 1;
         end
      end
      m_vb[k] = e.vb;
      if (s < N) m_pend[k] = s;
      e.act  = 3'(m_act[k]);
      e.busy = (m_lvl[k] != 4) || (m_pend[k] != m_act[k]);
      e.err  = (s >= N);
   endtask

   // One pixel of stimulus: drive inputs on the falling edge and queue the
   // predicted register contents after the next rising edge.
   task automatic tick(input int s, input bit r);
      exp_t e;
      @(negedge clk);
      sel = 3'(s);
      rst = r;
      for (int i = 0; i < N; i++) begin
         int vi;
         logic [11:0] c;
         vi = (i == 3) ? (v + 1) % VT : v;
         case (rgb_mode)
            1:       c = 12'hFFF;
            2:       c = 12'hABC;
            default: c = 12'($urandom);
         endcase
         src_hcount[i*11 +: 11] = 11'(h);
         src_vcount[i*11 +: 11] = 11'(vi);
         src_hsync[i] = (h == 13 || h == 14);
         src_vsync[i] = (vi == 6);
         src_hblnk[i] = (h >= 12);
         src_vblnk[i] = (vi >= 6);
         src_rgb[i*12 +: 12] = c;
      end
      model_step(0, 1'b1, r, s, e);
      q_fade.push_back(e);
      model_step(1, 1'b0, r, s, e);
      q_cut.push_back(e);
      h = h + 1;
      if (h == HT) begin
         h = 0;
         v = (v + 1) % VT;
      end
   endtask

   task automatic announce(input string what, input int s);
      txn = txn + 1;
      $display("txn %0d t=%0t %s sel=%0d mode=%0d", txn, $time, what, s, rgb_mode);
   endtask

   task automatic compare(input string name, input exp_t e, input exp_t g);
      checks = checks + 1;
      if (g !== e) begin
         errors = errors + 1;
         $display("FAIL %s t=%0t got hc=%0d vc=%0d hs=%0b vs=%0b hb=%0b vb=%0b rgb=%h act=%0d busy=%0b err=%0b | want hc=%0d vc=%0d hs=%0b vs=%0b hb=%0b vb=%0b rgb=%h act=%0d busy=%0b err=%0b",
                  name, $time, g.hc, g.vc, g.hs, g.vs, g.hb, g.vb, g.rgb, g.act, g.busy, g.err,
                  e.hc, e.vc, e.hs, e.vs, e.hb, e.vb, e.rgb, e.act, e.busy, e.err);
      end
   endtask

   // Monitor: after every rising edge compare each DUT with its queued prediction.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q_fade.size() > 0)
            compare("fade", q_fade.pop_front(),
                    exp_t'({out_fade.hcount, out_fade.vcount, out_fade.hsync, out_fade.vsync,
                            out_fade.hblnk, out_fade.vblnk, out_fade.rgb, act_fade, busy_fade, err_fade}));
         if (q_cut.size() > 0)
            compare("cut", q_cut.pop_front(),
                    exp_t'({out_cut.hcount, out_cut.vcount, out_cut.hsync, out_cut.vsync,
                            out_cut.hblnk, out_cut.vblnk, out_cut.rgb, act_cut, busy_cut, err_cut}));
      end
   end

   initial begin
      int cur;
      int n;
      m_act = '{0, 0}; m_pend = '{0, 0}; m_lvl = '{4, 4}; m_vb = '{1'b0, 1'b0};

      // Reset held with a pending request that must be ignored.
      announce("reset", 2);
      tick(2, 1'b1);
      tick(2, 1'b1);

      // Steady white on screen 0, then a full fade to screen 1.
      rgb_mode = 1;
      cur = 0;
      announce("show", cur);
      repeat (200) tick(cur, 1'b0);
      cur = 1;
      announce("fade", cur);
      repeat (12 * HT * VT) tick(cur, 1'b0);

      // Start fading toward 2, reverse at brightness 2.
      cur = 2;
      announce("fade", cur);
      n = 0;
      while (m_lvl[0] != 2 && n < 2000) begin
         tick(cur, 1'b0);
         n = n + 1;
      end
      checks = checks + 1;
      if (m_lvl[0] != 2) begin
         errors = errors + 1;
         $display("FAIL reversal_wait level=%0d want 2 after %0d cycles", m_lvl[0], n);
      end
      cur = 1;
      announce("reverse", cur);
      repeat (6 * HT * VT) tick(cur, 1'b0);

      // Out-of-range selects: flagged, otherwise ignored.
      announce("invalid", 5);
      repeat (300) tick(5, 1'b0);
      announce("invalid", 7);
      repeat (30) tick(7, 1'b0);

      // Blanking must force black regardless of source colour.
      rgb_mode = 2;
      cur = 3;
      announce("blank", cur);
      repeat (10 * HT * VT) tick(cur, 1'b0);

      // Reset in the middle of a fade.
      rgb_mode = 0;
      cur = 0;
      announce("fade", cur);
      repeat (3 * HT * VT) tick(cur, 1'b0);
      announce("reset", cur);
      tick(cur, 1'b1);
      repeat (2 * HT * VT) tick(cur, 1'b0);

      // Random requests (valid and invalid) with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bit r;
         r = 1'b0;
         if ($urandom_range(0, 149) == 0) begin
            cur = $urandom_range(0, 7);
            announce("random", cur);
         end
         if ($urandom_range(0, 1999) == 0) begin
            r = 1'b1;
            announce("reset", cur);
         end
         tick(cur, r);
      end

      @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
